// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among four requesters.
// Grants the port, runs a valid/ready transfer with optional timeout, then pulses done.
module mem_port_arbiter #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic       err,
  output logic [1:0] mem_sel,
  output logic       mem_valid,
  input  logic       mem_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t               state_reg;
  logic [3:0]           gnt_reg;
  logic [3:0]           done_reg;
  logic                 err_reg;
  logic [1:0]           sel_reg;
  logic                 valid_reg;
  logic                 busy_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [1:0]           last_reg;

  logic [1:0] cand     [4];
  logic [3:0] cand_hit;
  logic [1:0] win_idx;
  logic [3:0] win_onehot;
  logic [3:0] sel_onehot;
  logic       timeout_hit;

  // Candidate gi is the requester gi+1 positions after the last one served.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rr
      assign cand[gi]       = last_reg + 2'(gi + 1);
      assign cand_hit[gi]   = req[cand[gi]];
      assign win_onehot[gi] = (win_idx == 2'(gi));
      assign sel_onehot[gi] = (sel_reg == 2'(gi));
    end
  endgenerate

  always_comb begin
    win_idx = cand[3];
    for (int i = 3; i >= 0; i--) begin
      if (cand_hit[i]) win_idx = cand[i];
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
      done_reg  <= '0;
      err_reg   <= 1'b0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      last_reg  <= 2'd3;
    end else begin
      done_reg <= '0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            gnt_reg   <= win_onehot;
            sel_reg   <= win_idx;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_WIDTH'(1);
          // A ready in the timeout cycle still counts as a normal completion.
          if (mem_ready || timeout_hit) begin
            valid_reg <= 1'b0;
            gnt_reg   <= '0;
            done_reg  <= sel_onehot;
            err_reg   <= !mem_ready;
            last_reg  <= sel_reg;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign mem_sel   = sel_reg;
  assign mem_valid = valid_reg;
  assign busy      = busy_reg;

endmodule
